// File: rtl/regfile_sequencer.sv
// Multi-cycle sequencer for a 4x4-bit register file.
// Accepts one 8-bit instruction per handshake. It reads the two source registers,
// runs a 4-bit ALU op and writes the result back to the register file.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for an instruction; instr_ready high
// S_READ | rs1/rs2 driven, register file read data settling
// S_EXEC | ru1/ru2 sampled, ALU result captured in result_q
// S_WB   | write-back strobe and done pulse; flags commit on exit
module regfile_sequencer #(
  parameter bit ENABLE_LDI = 1'b1,
  parameter bit REG0_RO    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  output logic [1:0] rs1,
  output logic [1:0] rs2,
  input  logic [3:0] ru1,
  input  logic [3:0] ru2,
  output logic [1:0] rd,
  output logic       RuWr,
  output logic [3:0] RuWrData,
  output logic       busy,
  output logic       done,
  output logic       flag_zero,
  output logic       flag_carry
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [1:0]  rs1_q, rs2_q, rd_q;
  logic [4:0]  result_q;
  logic        zero_q, carry_q;
  logic        accept;
  logic        is_nop;

  // Opcode 11 becomes a pure sequencing slot when load-immediate is disabled.
  assign is_nop = (op_q == OP_LDI) && !ENABLE_LDI;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; outputs depend only on registered state
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    RuWr        = 1'b0;
    RuWrData    = 4'h0;
    case (state_q)
      S_IDLE: begin
        busy        = 1'b0;
        instr_ready = !rst;
        accept      = instr_valid && !rst;
        if (accept) begin
          state_d = (instr[7:6] == OP_LDI) ? S_WB : S_READ;
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB: begin
        done     = 1'b1;
        RuWr     = !(is_nop || (REG0_RO && (rd_q == 2'd0)));
        RuWrData = result_q[3:0];
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Instruction latch, ALU result capture and flag commit
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_ADD;
      rs1_q    <= 2'd0;
      rs2_q    <= 2'd0;
      rd_q     <= 2'd0;
      result_q <= 5'd0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= instr[7:6];
        rd_q  <= instr[5:4];
        rs1_q <= instr[3:2];
        rs2_q <= instr[1:0];
        if (ENABLE_LDI && (instr[7:6] == OP_LDI)) begin
          result_q <= {1'b0, instr[3:0]};
        end
      end
      if (state_q == S_EXEC) begin
        case (op_q)
          OP_ADD:  result_q <= {1'b0, ru1} + {1'b0, ru2};
          OP_SUB:  result_q <= {(ru1 < ru2), ru1 - ru2};
          OP_AND:  result_q <= {1'b0, ru1 & ru2};
          default: result_q <= result_q;
        endcase
      end
      if ((state_q == S_WB) && !is_nop) begin
        zero_q <= (result_q[3:0] == 4'h0);
        if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
          carry_q <= result_q[4];
        end
      end
    end
  end

  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign rd         = rd_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Multi-cycle control unit for the CPU's 4-entry x 4-bit register file (2 async read ports, 1 sync write port).
- Accepts one 8-bit instruction at a time over a valid/ready handshake.
- Sequences register reads, executes a 4-bit ALU op internally, and drives the write-back port.
- Sits between the instruction source (fetch/testbench) and the register file; sole owner of rs1/rs2/rd/RuWr/RuWrData.

Parameters:
ENABLE_LDI, 1, 1 = opcode 11 is load-immediate; 0 = opcode 11 is NOP (no write, no flag update, done still pulses)
REG0_RO, 0, 1 = writes targeting rd=0 are suppressed (RuWr held 0, flags still update, done still pulses)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  sequencer can accept; transfer when instr_valid && instr_ready on a rising edge
instr  input  8  [7:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2; LDI immediate = [3:0]
rs1  output  2  register file read select A
rs2  output  2  register file read select B
ru1  input  4  register file read data A (combinational from rs1)
ru2  input  4  register file read data B (combinational from rs2)
rd  output  2  register file write select
RuWr  output  1  register file write enable
RuWrData  output  4  register file write data
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in the WB cycle of each instruction
flag_zero  output  1  result == 0 of last completed instruction
flag_carry  output  1  carry (ADD) / borrow (SUB) of last ALU add/sub

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- States: IDLE, READ, EXEC, WB.
- Reset (any state, including mid-instruction): next state IDLE; in-flight instruction discarded; RuWr=0, done=0, rs1=rs2=rd=0, RuWrData=0, flag_zero=0, flag_carry=0, busy=0.
- instr_ready = (state==IDLE) && !rst.
- IDLE: on handshake, latch instr.
  - Opcodes 00/01/10 -> READ.
  - Opcode 11 -> WB directly (LDI, or NOP when ENABLE_LDI=0).
  - No handshake -> stay in IDLE.
- rs1, rs2, rd are registered from the latched fields; stable from the cycle after acceptance until the next acceptance.
- READ: rs1/rs2 driven; register file settles. -> EXEC.
- EXEC: sample ru1/ru2 and compute a 5-bit result into a result register. -> WB.
  - 00 ADD: {c,r} = ru1 + ru2.
  - 01 SUB: r = ru1 - ru2 mod 16; c = (ru1 < ru2).
  - 10 AND: r = ru1 & ru2; c unchanged.
- WB: RuWr=1, RuWrData=result, done=1. -> IDLE next cycle.
  - RuWr forced 0 when (REG0_RO && rd==0) or (opcode 11 && !ENABLE_LDI).
- Flags update at the WB edge:
  - flag_zero = (result==0) for ADD/SUB/AND/LDI.
  - flag_carry updated for ADD/SUB only.
  - NOP updates neither flag.
- Latency from the acceptance edge T:
  - ALU ops: RuWr high in cycle T+3; instr_ready high again at T+4.
  - LDI: RuWr high in cycle T+1; instr_ready high at T+2.
- Back-to-back: no same-cycle re-accept in WB. A following instruction's READ is at least 2 cycles after the prior WB, so no RAW hazard or forwarding is needed.
- instr_valid while busy is ignored; the instruction must be held by the source until ready.
- Outputs RuWr/done/RuWrData are decoded from registered state only; no combinational path from instr to any output except via instr_ready.

Test Plan:
- Reset then LDI r1,5 (0xC5) -> RuWr=1, rd=1, RuWrData=5 at T+1; flag_zero=0; done pulses once; instr_ready high at T+2.
- Preload r1=9, r2=8; ADD r3,r1,r2 (0x36) -> READ rs1=1, rs2=2; WB at T+3 with RuWrData=1; flag_carry=1, flag_zero=0.
- r1=3, r2=5; SUB r0,r1,r2 (0x46) -> RuWrData=0xE, flag_carry=1. Repeat with REG0_RO=1 -> RuWr stays 0, done still pulses, flags still update.
- AND giving 0 (r1=0xA, r2=5) -> flag_zero=1, flag_carry holds prior value. Also hold instr_valid high across busy -> exactly one acceptance per IDLE.
- Assert rst during EXEC of an ADD -> next cycle IDLE, RuWr never asserts, flags=0, target register unchanged.
- ENABLE_LDI=0, instr 0xFF -> no write, done pulses at T+1, flags unchanged.
